// File: rtl/irq_controller.sv
// Interrupt controller with one gateway per source, fixed-priority
// selection (lowest ID wins) and a claim/complete handshake toward a single
// external-interrupt line.
module irq_controller #(
  parameter int unsigned        NUM_IRQ   = 3,
  parameter int unsigned        ID_WIDTH  = $clog2(NUM_IRQ + 1),
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic [NUM_IRQ-1:0]  irq_i,
  input  logic [NUM_IRQ-1:0]  enable_i,
  input  logic                claim_i,
  input  logic                complete_i,
  input  logic [ID_WIDTH-1:0] complete_id_i,
  output logic                irq_o,
  output logic                claim_valid_o,
  output logic [ID_WIDTH-1:0] claim_id_o,
  output logic [NUM_IRQ-1:0]  pending_o,
  output logic [NUM_IRQ-1:0]  in_service_o
);

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StInService
  } gw_state_e;

  gw_state_e state_q [NUM_IRQ];
  gw_state_e state_d [NUM_IRQ];

  logic [NUM_IRQ-1:0]  prev_q;
  logic [NUM_IRQ-1:0]  edge_seen_q, edge_seen_d;
  logic [NUM_IRQ-1:0]  pending, in_service, eligible;
  logic [NUM_IRQ-1:0]  trigger, complete_hit, claim_hit;
  logic                irq_q;
  logic                claim_valid_q;
  logic [ID_WIDTH-1:0] claim_id_q, claim_id_d;
  logic [ID_WIDTH-1:0] sel_id;

  // Decode gateway states into flat status vectors.
  always_comb begin
    pending    = '0;
    in_service = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pending[i]    = (state_q[i] == StPending);
      in_service[i] = (state_q[i] == StInService);
    end
  end

  // Fixed-priority pick: scan downward so the lowest eligible ID is written last.
  always_comb begin
    eligible = pending & enable_i;
    sel_id   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_id = ID_WIDTH'(i + 1);
      end
    end
  end

  // Per-source trigger, completion match and claim match.
  always_comb begin
    trigger      = '0;
    complete_hit = '0;
    claim_hit    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      trigger[i]      = EDGE_MASK[i] ? (irq_i[i] & ~prev_q[i]) : irq_i[i];
      complete_hit[i] = complete_i && (complete_id_i == ID_WIDTH'(i + 1));
      claim_hit[i]    = claim_i && (sel_id == ID_WIDTH'(i + 1));
    end
  end

  // Gateway next-state logic and claim result.
  always_comb begin
    claim_id_d = claim_i ? sel_id : claim_id_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      state_d[i]     = state_q[i];
      edge_seen_d[i] = edge_seen_q[i];
      case (state_q[i])
        StIdle: begin
          if (trigger[i]) begin
            state_d[i] = StPending;
          end
        end
        StPending: begin
          // Held until claimed; level drop or disable does not clear it.
          if (claim_hit[i]) begin
            state_d[i] = StInService;
            if (EDGE_MASK[i] && trigger[i]) begin
              edge_seen_d[i] = 1'b1;
            end
          end
        end
        StInService: begin
          if (complete_hit[i]) begin
            // An edge caught during service (or on this very edge) re-arms the source.
            if (EDGE_MASK[i] && (edge_seen_q[i] || trigger[i])) begin
              state_d[i] = StPending;
            end else begin
              state_d[i] = StIdle;
            end
            edge_seen_d[i] = 1'b0;
          end else if (EDGE_MASK[i] && trigger[i]) begin
            edge_seen_d[i] = 1'b1;
          end
        end
        default: begin
          state_d[i]     = StIdle;
          edge_seen_d[i] = 1'b0;
        end
      endcase
    end
  end

  // State registers; irq_o reflects the eligibility of the previous cycle.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        state_q[i] <= StIdle;
      end
      prev_q        <= '0;
      edge_seen_q   <= '0;
      irq_q         <= 1'b0;
      claim_valid_q <= 1'b0;
      claim_id_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        state_q[i] <= state_d[i];
      end
      prev_q        <= irq_i;
      edge_seen_q   <= edge_seen_d;
      irq_q         <= |eligible;
      claim_valid_q <= claim_i;
      claim_id_q    <= claim_id_d;
    end
  end

  assign irq_o         = irq_q;
  assign claim_valid_o = claim_valid_q;
  assign claim_id_o    = claim_id_q;
  assign pending_o     = pending;
  assign in_service_o  = in_service;

endmodule
